// File: rtl/ram256_wb_ctrl.sv
// ram256_wb_ctrl: Wishbone classic slave driving a single RAM256 macro.
// Each strobed transfer becomes one EN0 pulse on the RAM and one registered
// ack, two cycles after the request is sampled (1 transfer per 3 cycles).
// Optional build macro RAM256_WB_RDREG_EN inserts a WAIT state and registers
// the read data, for 3-cycle latency (1 transfer per 4 cycles).
module ram256_wb_ctrl #(
    parameter int WSIZE  = 4,
    parameter int AW_LSB = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WSIZE-1:0]     wb_sel_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WSIZE*8-1:0]   wb_dat_i,
    output logic [WSIZE*8-1:0]   wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 ram_en0,
    output logic [WSIZE-1:0]     ram_we0,
    output logic [7:0]           ram_a0,
    output logic [WSIZE*8-1:0]   ram_di0,
    input  logic [WSIZE*8-1:0]   ram_do0
);

    localparam int DW = WSIZE * 8;

    // WAIT is only reachable when read data is registered.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t             state_q;
    logic               ack_q;
    logic               en_q;
    logic [WSIZE-1:0]   we_q;
    logic [7:0]         a_q;
    logic [DW-1:0]      di_q;
    logic               rd_q;    // current transfer is a read
    logic [DW-1:0]      rdata_d; // read data source presented during ACK

`ifdef RAM256_WB_RDREG_EN
    logic               live_q;  // cyc was still high when the RAM sampled
    logic [DW-1:0]      rdata_q;
`endif

    // Byte-offset and above-window address bits do not select a RAM word.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:AW_LSB+8], wb_adr_i[AW_LSB-1:0]};

    // Transfer FSM: accepts a request in IDLE, issues one RAM strobe, acks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: address/data holding registers are reset too, so the RAM
            // pins are at a known value out of reset, not just the control.
            state_q <= IDLE;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= '0;
            a_q     <= '0;
            di_q    <= '0;
            rd_q    <= 1'b0;
`ifdef RAM256_WB_RDREG_EN
            live_q  <= 1'b0;
            rdata_q <= '0;
`endif
        end else begin
            // NOTE: every register here uses <=, so all branches see the
            // pre-edge values and the order of statements does not matter.
            unique case (state_q)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        en_q    <= 1'b1;
                        a_q     <= wb_adr_i[AW_LSB+7:AW_LSB];
                        di_q    <= wb_dat_i;
                        we_q    <= wb_we_i ? wb_sel_i : '0;
                        rd_q    <= ~wb_we_i;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM samples EN0/WE0 at this edge; the operation
                    // completes even if the master has dropped cyc.
                    en_q <= 1'b0;
                    we_q <= '0;
`ifdef RAM256_WB_RDREG_EN
                    live_q  <= wb_cyc_i;
                    state_q <= WAIT;
`else
                    ack_q   <= wb_cyc_i;
                    state_q <= ACK;
`endif
                end
`ifdef RAM256_WB_RDREG_EN
                WAIT: begin
                    ack_q <= live_q & wb_cyc_i;
                    if (rd_q) begin
                        rdata_q <= ram_do0;
                    end
                    state_q <= ACK;
                end
`endif
                ACK: begin
                    // A stb still high here belongs to the acked transfer.
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data is presented only during ACK of a read; zero otherwise.
    always_comb begin
`ifdef RAM256_WB_RDREG_EN
        rdata_d = rdata_q;
`else
        rdata_d = ram_do0;
`endif
        wb_dat_o = '0;
        if (state_q == ACK && rd_q) begin
            wb_dat_o = rdata_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign ram_en0  = en_q;
    assign ram_we0  = we_q;
    assign ram_a0   = a_q;
    assign ram_di0  = di_q;

endmodule

// File: tb/tb_ram256_wb_ctrl.sv
// Self-checking bench for ram256_wb_ctrl with a behavioural RAM256 model and
// a scoreboard queue of expected transfer results.
module tb_ram256_wb_ctrl;

`ifdef RAM256_WB_RDREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_ack_o, ram_en0;
    logic [3:0]  ram_we0;
    logic [7:0]  ram_a0;
    logic [31:0] ram_di0, ram_do0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t     sb[$];
    bit [31:0] ref_mem [256];
    bit [31:0] ram_mem [256];

    ram256_wb_ctrl #(.WSIZE(4), .AW_LSB(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .ram_en0  (ram_en0),
        .ram_we0  (ram_we0),
        .ram_a0   (ram_a0),
        .ram_di0  (ram_di0),
        .ram_do0  (ram_do0)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM256: synchronous, byte-writable, registered Do0.
    always @(posedge CLK) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we0[b]) ram_mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
            end
            ram_do0 <= ram_mem[ram_a0];
        end
    end

    function automatic void model_write(input logic [31:0] adr, input logic [3:0] sel,
                                        input logic [31:0] dat);
        logic [7:0] w;
        w = adr[9:2];
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
        end
    endfunction

    // One transfer. pre = extra cycles before the FSM can sample (1 when the
    // previous transfer was left with stb high through its ACK cycle).
    task automatic do_xfer(input string name, input bit we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input int pre, input bit keep);
        exp_t e;
        int n;
        bit got;
        logic [7:0] w;
        w = adr[9:2];
        if (we) model_write(adr, sel, dat);
        e.rd   = ~we;
        e.data = we ? 32'h0 : ref_mem[w];
        sb.push_back(e);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_sel_i = sel;  wb_adr_i = adr;  wb_dat_i = dat;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge CLK); @(negedge CLK); n++;
            if (n == 1 + pre) begin
                checks++;
                if (ram_en0 !== 1'b1 || ram_a0 !== w || ram_we0 !== (we ? sel : 4'h0)
                    || ram_di0 !== dat) begin
                    errors++;
                    $display("FAIL %s ram strobe: en=%b a0=%h we0=%h di0=%h required en=1 a0=%h we0=%h di0=%h",
                             name, ram_en0, ram_a0, ram_we0, ram_di0, w, we ? sel : 4'h0, dat);
                end
            end
            if (wb_ack_o === 1'b1) begin
                got = 1;
                e = sb.pop_front();
                checks++;
                if (n != LAT + pre) begin
                    errors++;
                    $display("FAIL %s latency: ack after %0d cycles, required %0d", name, n, LAT + pre);
                end
                checks++;
                if (wb_dat_o !== e.data) begin
                    errors++;
                    $display("FAIL %s data: got %h required %h", name, wb_dat_o, e.data);
                end
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout: no ack within 20 cycles, required ack", name);
            void'(sb.pop_front());
        end
        if (!keep) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
                errors++;
                $display("FAIL %s after ack: ack=%b dat=%h required ack=0 dat=0", name, wb_ack_o, wb_dat_o);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || ram_en0 !== 1'b0 ||
            ram_we0 !== 4'h0 || ram_a0 !== 8'h0 || ram_di0 !== 32'h0) begin
            errors++;
            $display("FAIL %s: ack=%b dat=%h en=%b we=%h a0=%h di0=%h required all 0",
                     name, wb_ack_o, wb_dat_o, ram_en0, ram_we0, ram_a0, ram_di0);
        end
    endtask

    task automatic test_reset();
        int acks;
        RST = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_idle_outputs("reset values");
        acks = 0;
        repeat (3) begin
            @(posedge CLK); @(negedge CLK);
            if (wb_ack_o !== 1'b0 || ram_en0 !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL idle no activity: %0d active cycles, required 0", acks);
        end
    endtask

    task automatic test_write_read();
        do_xfer("full write", 1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 0, 0);
        do_xfer("full read",  0, 32'h0000_0010, 4'hF, 32'h0,        0, 0);
    endtask

    task automatic test_byte_lanes();
        do_xfer("lane prefill", 1, 32'h0000_0200, 4'hF, 32'hAAAAAAAA, 0, 0);
        do_xfer("lane write",   1, 32'h0000_0200, 4'b0101, 32'h11223344, 0, 0);
        do_xfer("lane sel0",    1, 32'h0000_0200, 4'b0000, 32'hFFFFFFFF, 0, 0);
        do_xfer("lane read",    0, 32'h0000_0200, 4'hF, 32'h0, 0, 0);
        checks++;
        if (ref_mem[8'h80] !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL lane model: %h required AA22AA44", ref_mem[8'h80]);
        end
    endtask

    task automatic test_bank_cross();
        do_xfer("bank w7f", 1, 32'h0000_01FC, 4'hF, 32'h1, 0, 0);
        do_xfer("bank w80", 1, 32'h0000_0200, 4'hF, 32'h2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_xfer("bank read", 0, (i % 2 == 0) ? 32'h0000_01FC : 32'h0000_0200, 4'hF, 32'h0, 0, 0);
        end
        do_xfer("wrap write", 1, 32'h0000_0400, 4'hF, 32'hC0FFEE00, 0, 0);
        do_xfer("wrap read",  0, 32'h0000_0000, 4'hF, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int acks;
        do_xfer("b2b write", 1, 32'h0000_0040, 4'hF, 32'h0BAD_CAFE, 0, 1);
        do_xfer("b2b read",  0, 32'h0000_0040, 4'hF, 32'h0, 1, 1);
        do_xfer("b2b read2", 0, 32'h0000_0010, 4'hF, 32'h0, 1, 0);
        // Abort: cyc drops while the RAM strobe is out.
        model_write(32'h0000_0080, 4'hF, 32'h5555AAAA);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
        wb_adr_i = 32'h0000_0080; wb_dat_i = 32'h5555AAAA;
        @(posedge CLK); @(negedge CLK);
        wb_cyc_i = 0; wb_stb_i = 0;
        acks = 0;
        repeat (LAT + 2) begin
            @(posedge CLK); @(negedge CLK);
            if (wb_ack_o !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort ack: %0d acks, required 0", acks);
        end
        do_xfer("abort readback", 0, 32'h0000_0080, 4'hF, 32'h0, 0, 0);
    endtask

    task automatic test_reset_inflight();
        model_write(32'h0000_0030, 4'hF, 32'h0BADF00D);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
        wb_adr_i = 32'h0000_0030; wb_dat_i = 32'h0BADF00D;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check_idle_outputs("reset in flight");
        wb_cyc_i = 0; wb_stb_i = 0;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        do_xfer("reset readback", 0, 32'h0000_0030, 4'hF, 32'h0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_bank_cross();
        test_back_to_back();
        test_reset_inflight();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
